mem_port_arbiter: RTL

- Shares one single-port memory bus between instruction fetch (driven by the PC register's pc/ce) and the MEM-stage load/store unit.
- Raises per-requester stall requests toward the pipeline controller until each access completes.
- Holds fetched instruction and load data until the owning pipeline stage advances.
- Handles pipeline flushes during an in-flight bus transaction.

---
 rtl/mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-port memory bus between instruction fetch (PC pc/ce) and the
// MEM-stage load/store unit. Each requester sees a combinational stall request
// until its access has completed. The returned instruction/load data is held,
// together with a valid flag, until the owning pipeline stage advances. Load and
// store requests always win over fetch. A flush during an in-flight bus
// transaction lets the handshake finish but discards the returned data.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog aborts any access that
// receives no ack within TIMEOUT_CYCLES busy cycles. The owner then receives
// zero data with its valid flag set, and bus_err_o pulses for one cycle.
// Without the macro, bus_err_o stays 0 and a missing ack stalls forever.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_i[5:0]     pipeline stall vector ([1]=IF/ID hold, [4]=MEM/WB hold)
//   flush_i          pipeline flush (exception/eret)
//   if_ce_i          fetch enable
//   if_addr_i        fetch address
//   if_inst_o        fetched instruction (held)
//   if_stallreq_o    fetch stall request
//   mem_ce_i         data access request
//   mem_we_i         1 = store
//   mem_addr_i       data address
//   mem_wdata_i      store data
//   mem_sel_i        byte enables
//   mem_rdata_o      load data (held)
//   mem_stallreq_o   data stall request
//   bus_req_o        bus request, held until ack
//   bus_we_o         bus write
//   bus_addr_o       bus address
//   bus_wdata_o      bus write data
//   bus_sel_o        bus byte enables
//   bus_ack_i        bus completion, one-cycle pulse
//   bus_rdata_i      bus read data, valid with ack
//   bus_err_o        watchdog timeout pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_stallreq_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [3:0]        mem_sel_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_valid_q, mem_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout_hit;

    // Only the IF/ID and MEM/WB hold bits matter to this block.
    logic unused_ok;
    assign unused_ok = ^{stall_i[5], stall_i[3:2], stall_i[0], TIMEOUT_CYCLES[0]};

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter restarts whenever the state changes, so each BUSY/DRAIN visit
    // gets a fresh TIMEOUT_CYCLES budget; the limit is hit in the last
    // allowed busy cycle so the abort lands at that edge.
    assign timeout_hit = (state_q != IDLE) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if ((state_d == state_q) && (state_q != IDLE)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign if_stallreq_o  = if_ce_i & ~if_valid_q;
    assign mem_stallreq_o = mem_ce_i & ~mem_valid_q;

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;
    assign if_inst_o   = if_inst_q;
    assign mem_rdata_o = mem_rdata_q;
    assign bus_err_o   = bus_err_q;

    // Next-state logic. Valid flags first take their "stage advanced" clear,
    // then a completing access may set them again, giving set priority.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        if_valid_d  = if_valid_q & stall_i[1] & ~flush_i;
        mem_valid_d = mem_valid_q & stall_i[4] & ~flush_i;

        case (state_q)
            IDLE: begin
                // MEM belongs to the older instruction, so it is served first.
                if (mem_ce_i && !mem_valid_q && !flush_i) begin
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    bus_sel_d   = mem_sel_i;
                    bus_req_d   = 1'b1;
                    state_d     = MEM_BUSY;
                end else if (if_ce_i && !if_valid_q && !flush_i) begin
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr_i;
                    bus_sel_d  = 4'hF;
                    bus_req_d  = 1'b1;
                    state_d    = IF_BUSY;
                end
            end

            IF_BUSY, MEM_BUSY: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                    // A coincident flush completes the handshake but the
                    // owning instruction is gone, so nothing is delivered.
                    if (!flush_i) begin
                        if (state_q == MEM_BUSY) begin
                            mem_valid_d = 1'b1;
                            if (!bus_we_q) begin
                                mem_rdata_d = bus_rdata_i;
                            end
                        end else begin
                            if_valid_d = 1'b1;
                            if_inst_d  = bus_rdata_i;
                        end
                    end
                end else if (flush_i) begin
                    // The bus cannot be aborted; wait out the ack elsewhere.
                    state_d = DRAIN;
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    if (state_q == MEM_BUSY) begin
                        mem_rdata_d = '0;
                        mem_valid_d = 1'b1;
                    end else begin
                        if_inst_d  = '0;
                        if_valid_d = 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (bus_ack_i || timeout_hit) begin
                    bus_req_d = 1'b0;
                    bus_err_d = timeout_hit & ~bus_ack_i;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= 4'h0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule
